// File: rtl/rotary_step_decoder.sv
// rotary_step_decoder
// Paddle-input decoder: synchronises and debounces an N_POS-wide one-hot sensor bus, turns each
// single-step move (with wrap-around) into a one-cycle left/right pulse, keeps a saturating
// paddle position and flags illegal codes or skipped positions.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   in_p       in   raw sensor bus, asynchronous to clk
//   en         in   1: moves update pos and pulse left/right; 0: index tracking only
//   recenter   in   load pos with POS_INIT
//   left_op    out  one-cycle pulse, accepted move to index-1 (mod N_POS)
//   right_op   out  one-cycle pulse, accepted move to index+1 (mod N_POS)
//   err_op     out  one-cycle pulse, illegal code or skipped position accepted
//   pos        out  paddle position, saturating at 0 and POS_MAX
//   cur_idx    out  last accepted position index
//   idx_valid  out  a legal position has been accepted since reset
module rotary_step_decoder #(
    parameter int unsigned N_POS        = 3,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned POS_W        = 8,
    parameter int unsigned POS_MAX      = 200,
    parameter int unsigned POS_INIT     = 100,
    parameter int unsigned STEP         = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_POS-1:0]           in_p,
    input  logic                       en,
    input  logic                       recenter,
    output logic                       left_op,
    output logic                       right_op,
    output logic                       err_op,
    output logic [POS_W-1:0]           pos,
    output logic [$clog2(N_POS)-1:0]   cur_idx,
    output logic                       idx_valid
);

    localparam int unsigned IdxW  = $clog2(N_POS);
    localparam int unsigned CntW  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned OnesW = $clog2(N_POS + 1);
    localparam int unsigned PosXW = POS_W + 1;

    localparam logic [0:0] StAcquire = 1'b0;
    localparam logic [0:0] StTrack   = 1'b1;

    logic [N_POS-1:0] s1_q, s2_q, cand_q, cand_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             eval_q, eval_d;
    logic [0:0]       state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             left_q, left_d, right_q, right_d, err_q, err_d;

    logic             stable;
    logic [IdxW-1:0]  hot_idx, idx_inc, idx_dec;
    logic [OnesW-1:0] n_ones;
    logic [PosXW-1:0] pos_up, pos_dn;
    logic [POS_W-1:0] pos_inc, pos_dec;

    // Population count and (for one-hot codes) bit index of the candidate.
    always_comb begin
        hot_idx = '0;
        n_ones  = '0;
        for (int i = 0; i < N_POS; i++) begin
            if (cand_q[i]) begin
                hot_idx = IdxW'(i);
                n_ones  = n_ones + OnesW'(1);
            end
        end
    end

    assign idx_inc = (idx_q == IdxW'(N_POS - 1)) ? '0 : idx_q + IdxW'(1);
    assign idx_dec = (idx_q == '0) ? IdxW'(N_POS - 1) : idx_q - IdxW'(1);

    // One extra bit so overflow past POS_MAX and borrow below zero are both visible.
    assign pos_up  = {1'b0, pos_q} + PosXW'(STEP);
    assign pos_dn  = {1'b0, pos_q} - PosXW'(STEP);
    assign pos_inc = (pos_up > PosXW'(POS_MAX)) ? POS_W'(POS_MAX) : pos_up[POS_W-1:0];
    assign pos_dec = pos_dn[POS_W] ? '0 : pos_dn[POS_W-1:0];

    // Candidate is acted on once, on the cycle after its count first reaches DEBOUNCE_CYC.
    assign stable = (cnt_q == CntW'(DEBOUNCE_CYC)) && !eval_q;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        eval_d = eval_q;
        if (stable) begin
            eval_d = 1'b1;
        end
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = CntW'(1);
            eval_d = 1'b0;
        end else if (cnt_q != CntW'(DEBOUNCE_CYC)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        left_d  = 1'b0;
        right_d = 1'b0;
        err_d   = 1'b0;
        if (stable && (cand_q != '0)) begin
            if (n_ones > OnesW'(1)) begin
                err_d = 1'b1;
            end else if (state_q == StAcquire) begin
                idx_d   = hot_idx;
                state_d = StTrack;
            end else begin
                idx_d = hot_idx;
                if (hot_idx == idx_inc) begin
                    right_d = en;
                    if (en) pos_d = pos_inc;
                end else if (hot_idx == idx_dec) begin
                    left_d = en;
                    if (en) pos_d = pos_dec;
                end else if (hot_idx != idx_q) begin
                    err_d = 1'b1;
                end
            end
        end
        if (recenter) begin
            pos_d = POS_W'(POS_INIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            eval_q  <= 1'b0;
            state_q <= StAcquire;
            idx_q   <= '0;
            pos_q   <= POS_W'(POS_INIT);
            left_q  <= 1'b0;
            right_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= in_p;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            eval_q  <= eval_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            left_q  <= left_d;
            right_q <= right_d;
            err_q   <= err_d;
        end
    end

    assign left_op   = left_q;
    assign right_op  = right_q;
    assign err_op    = err_q;
    assign pos       = pos_q;
    assign cur_idx   = idx_q;
    assign idx_valid = (state_q == StTrack);

endmodule
